// File: rtl/memgame_pkg.sv
// Shared types and constants for the memory-game sequence engine.
// Holds the player state encoding, the blank display code and length-width helper.
package memgame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHOW,
      ST_GAP,
      ST_ENTRY,
      ST_FAIL
   } state_t;

   localparam logic [4:0] BLANK_CODE  = 5'd31;
   localparam int         DIGIT_W_DEF = 4;

   // Width needed to hold a count from 0 to max_len inclusive.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_mem.sv
// Digit store for the sequence player: one synchronous write port, one async read port.
// Contents are not reset; only entries below the current length are ever read back.
module seq_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 4,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Addresses beyond DEPTH only appear for non-power-of-two depths; read them as zero.
   assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/seq_player.sv
// Sequence store / playback / entry-check engine for the memory game.
// Optional build macro SEQ_AUTO_APPEND_EN: append rand_in on seq_done when not full.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting; append grows the sequence, play starts playback
//   ST_SHOW  | displaying mem[index], timer running
//   ST_GAP   | blank between digits, timer running
//   ST_ENTRY | comparing player entries against mem[index]
//   ST_FAIL  | wrong entry seen; hold until clear or replay
module seq_player
   import memgame_pkg::*;
#(
   parameter int         MAX_LEN = 16,
   parameter int         DIGIT_W = DIGIT_W_DEF,
   parameter logic [4:0] BLANK   = BLANK_CODE,
   localparam int        LEN_W   = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               append,
   input  logic [DIGIT_W-1:0] rand_in,
   input  logic               play,
   input  logic               tick,
   input  logic               check_valid,
   input  logic [DIGIT_W-1:0] check_digit,
   input  logic               clear,
   output logic               timer_en,
   output logic [4:0]         disp_digit,
   output logic               busy,
   output logic               full,
   output logic [LEN_W-1:0]   length,
   output logic               match,
   output logic               mismatch,
   output logic               seq_done
);

   localparam int               AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   state_t             state;
   state_t             state_nxt;
   logic [AW-1:0]      index;
   logic [AW-1:0]      index_nxt;
   logic [LEN_W-1:0]   length_nxt;
   logic               mem_we;
   logic [AW-1:0]      mem_raddr;
   logic [DIGIT_W-1:0] mem_rdata;
   logic               last_digit;
   logic               hit_match;
   logic               hit_mismatch;
   logic               hit_done;
   logic [4:0]         disp_nxt;
   logic               timer_nxt;
   logic               busy_nxt;
   logic               full_nxt;

   seq_mem #(
      .DEPTH (MAX_LEN),
      .WIDTH (DIGIT_W),
      .AW    (AW)
   ) u_seq_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (length[AW-1:0]),
      .wdata (rand_in),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   assign last_digit = (LEN_W'(index) == (length - 1'b1));

   // The single read port serves both the compare (ENTRY) and the digit about
   // to be displayed: entering SHOW from IDLE/FAIL shows digit 0, from GAP the next one.
   always_comb begin
      case (state)
         ST_GAP:            mem_raddr = index + 1'b1;
         ST_SHOW, ST_ENTRY: mem_raddr = index;
         default:           mem_raddr = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         index      <= '0;
         length     <= '0;
         disp_digit <= BLANK;
         timer_en   <= 1'b0;
         busy       <= 1'b0;
         full       <= 1'b0;
         match      <= 1'b0;
         mismatch   <= 1'b0;
         seq_done   <= 1'b0;
      end else begin
         state      <= state_nxt;
         index      <= index_nxt;
         length     <= length_nxt;
         disp_digit <= disp_nxt;
         timer_en   <= timer_nxt;
         busy       <= busy_nxt;
         full       <= full_nxt;
         match      <= hit_match;
         mismatch   <= hit_mismatch;
         seq_done   <= hit_done;
      end
   end

   always_comb begin
      state_nxt    = state;
      index_nxt    = index;
      length_nxt   = length;
      mem_we       = 1'b0;
      hit_match    = 1'b0;
      hit_mismatch = 1'b0;
      hit_done     = 1'b0;
      if (clear) begin
         state_nxt  = ST_IDLE;
         index_nxt  = '0;
         length_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (append) begin
                  if (!full) begin
                     mem_we     = 1'b1;
                     length_nxt = length + 1'b1;
                  end
               end else if (play && (length != '0)) begin
                  index_nxt = '0;
                  state_nxt = ST_SHOW;
               end
            end
            ST_SHOW: begin
               if (tick) begin
                  state_nxt = ST_GAP;
               end
            end
            ST_GAP: begin
               if (tick) begin
                  if (last_digit) begin
                     index_nxt = '0;
                     state_nxt = ST_ENTRY;
                  end else begin
                     index_nxt = index + 1'b1;
                     state_nxt = ST_SHOW;
                  end
               end
            end
            ST_ENTRY: begin
               if (check_valid) begin
                  if (check_digit == mem_rdata) begin
                     hit_match = 1'b1;
                     if (last_digit) begin
                        hit_done  = 1'b1;
                        index_nxt = '0;
                        state_nxt = ST_IDLE;
`ifdef SEQ_AUTO_APPEND_EN
                        if (!full) begin
                           mem_we     = 1'b1;
                           length_nxt = length + 1'b1;
                        end
`endif
                     end else begin
                        index_nxt = index + 1'b1;
                     end
                  end else begin
                     hit_mismatch = 1'b1;
                     state_nxt    = ST_FAIL;
                  end
               end
            end
            ST_FAIL: begin
               if (play) begin
                  index_nxt = '0;
                  state_nxt = ST_SHOW;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
               index_nxt = '0;
            end
         endcase
      end
   end

   always_comb begin
      disp_nxt = BLANK;
      if (state_nxt == ST_SHOW) begin
         disp_nxt = 5'(mem_rdata);
      end
      timer_nxt = (state_nxt == ST_SHOW) || (state_nxt == ST_GAP);
      busy_nxt  = (state_nxt != ST_IDLE);
      full_nxt  = (length_nxt == MAX_LEN_L);
   end

endmodule

// File: tb/tb_seq_player.sv
// Self-checking bench for seq_player: directed vector table, corner-case sequences,
// then random stimulus against a playback-position reference model.
module tb_seq_player;

`ifdef SEQ_AUTO_APPEND_EN
   localparam int AUTO = 1;
`else
   localparam int AUTO = 0;
`endif
   localparam int MAXL = 16;

   logic       clk;
   logic       rst_n;
   logic       append;
   logic [3:0] rand_in;
   logic       play;
   logic       tick;
   logic       check_valid;
   logic [3:0] check_digit;
   logic       clear;
   logic       timer_en;
   logic [4:0] disp_digit;
   logic       busy;
   logic       full;
   logic [4:0] length;
   logic       match;
   logic       mismatch;
   logic       seq_done;

   seq_player #(.MAX_LEN(MAXL)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .append      (append),
      .rand_in     (rand_in),
      .play        (play),
      .tick        (tick),
      .check_valid (check_valid),
      .check_digit (check_digit),
      .clear       (clear),
      .timer_en    (timer_en),
      .disp_digit  (disp_digit),
      .busy        (busy),
      .full        (full),
      .length      (length),
      .match       (match),
      .mismatch    (mismatch),
      .seq_done    (seq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the stored digits, plus how far playback has progressed.
   // ticks counts timer pulses since play: even -> digit ticks/2 shown, odd -> gap,
   // 2*len -> waiting for entries; entered counts correct entries so far.
   int mq[$];
   bit m_active;
   bit m_failed;
   int m_ticks;
   int m_entered;
   bit e_match;
   bit e_mis;
   bit e_done;

   typedef struct {
      bit         a;
      logic [3:0] rin;
      bit         p;
      bit         t;
      bit         cv;
      logic [3:0] cd;
      int         disp;
      bit         tim;
      bit         bsy;
      int         len;
      bit         m;
      bit         mm;
      bit         d;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(bit a, int rin, bit p, bit t, bit cv, int cd,
                               int disp, bit tim, bit bsy, int len, bit m, bit mm, bit d);
      vec_t v;
      v.a = a; v.rin = 4'(rin); v.p = p; v.t = t; v.cv = cv; v.cd = 4'(cd);
      v.disp = disp; v.tim = tim; v.bsy = bsy; v.len = len; v.m = m; v.mm = mm; v.d = d;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic bit in_playback();
      return m_active && !m_failed && (m_ticks < 2 * mq.size());
   endfunction

   function automatic bit in_entry();
      return m_active && !m_failed && (m_ticks >= 2 * mq.size());
   endfunction

   function automatic int exp_disp();
      if (in_playback() && (m_ticks % 2 == 0)) return mq[m_ticks / 2];
      return 31;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_active = 0; m_failed = 0; m_ticks = 0; m_entered = 0;
      e_match = 0; e_mis = 0; e_done = 0;
   endtask

   task automatic model_step(bit a, int rin, bit p, bit t, bit cv, int cd, bit cl);
      e_match = 0; e_mis = 0; e_done = 0;
      if (cl) begin
         mq.delete();
         m_active = 0;
      end else if (!m_active) begin
         if (a) begin
            if (mq.size() < MAXL) mq.push_back(rin);
         end else if (p && mq.size() > 0) begin
            m_active = 1; m_failed = 0; m_ticks = 0; m_entered = 0;
         end
      end else if (m_failed) begin
         if (p) begin
            m_failed = 0; m_ticks = 0; m_entered = 0;
         end
      end else if (m_ticks < 2 * mq.size()) begin
         if (t) m_ticks++;
      end else if (cv) begin
         if (cd == mq[m_entered]) begin
            e_match = 1;
            m_entered++;
            if (m_entered == mq.size()) begin
               e_done   = 1;
               m_active = 0;
               if (AUTO == 1 && mq.size() < MAXL) mq.push_back(rin);
            end
         end else begin
            e_mis    = 1;
            m_failed = 1;
         end
      end
   endtask

   task automatic check_all(string tag);
      chk({tag, ".disp"},     disp_digit, exp_disp());
      chk({tag, ".timer"},    timer_en,   in_playback());
      chk({tag, ".busy"},     busy,       m_active);
      chk({tag, ".len"},      length,     mq.size());
      chk({tag, ".full"},     full,       mq.size() == MAXL);
      chk({tag, ".match"},    match,      e_match);
      chk({tag, ".mismatch"}, mismatch,   e_mis);
      chk({tag, ".done"},     seq_done,   e_done);
   endtask

   task automatic cyc(string tag, bit a, int rin, bit p, bit t, bit cv, int cd, bit cl);
      append = a; rand_in = 4'(rin); play = p; tick = t;
      check_valid = cv; check_digit = 4'(cd); clear = cl;
      model_step(a, rin, p, t, cv, cd, cl);
      @(posedge clk);
      #1;
      check_all(tag);
      append = 0; play = 0; tick = 0; check_valid = 0; clear = 0;
   endtask

   initial begin
      rst_n = 0; append = 0; rand_in = 0; play = 0; tick = 0;
      check_valid = 0; check_digit = 0; clear = 0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

      tbl[0]  = mk(1, 7, 0, 0, 0, 0, 31, 0, 0, 1, 0, 0, 0);
      tbl[1]  = mk(1, 2, 0, 0, 0, 0, 31, 0, 0, 2, 0, 0, 0);
      tbl[2]  = mk(1, 9, 0, 0, 0, 0, 31, 0, 0, 3, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 0, 0, 0,  7, 1, 1, 3, 0, 0, 0);
      tbl[4]  = mk(0, 0, 0, 1, 0, 0, 31, 1, 1, 3, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 0,  2, 1, 1, 3, 0, 0, 0);
      tbl[6]  = mk(0, 0, 0, 1, 0, 0, 31, 1, 1, 3, 0, 0, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0, 0,  9, 1, 1, 3, 0, 0, 0);
      tbl[8]  = mk(0, 0, 0, 1, 0, 0, 31, 1, 1, 3, 0, 0, 0);
      tbl[9]  = mk(0, 0, 0, 1, 0, 0, 31, 0, 1, 3, 0, 0, 0);
      tbl[10] = mk(0, 0, 0, 0, 1, 7, 31, 0, 1, 3, 1, 0, 0);
      tbl[11] = mk(0, 0, 0, 0, 1, 2, 31, 0, 1, 3, 1, 0, 0);
      tbl[12] = mk(0, 4, 0, 0, 1, 9, 31, 0, 0, 3 + AUTO, 1, 0, 1);

      for (int i = 0; i < 13; i++) begin
         string tg;
         tg = $sformatf("vec%0d", i);
         cyc(tg, tbl[i].a, tbl[i].rin, tbl[i].p, tbl[i].t, tbl[i].cv, tbl[i].cd, 0);
         chk({tg, ".tbl_disp"},  disp_digit, tbl[i].disp);
         chk({tg, ".tbl_timer"}, timer_en,   tbl[i].tim);
         chk({tg, ".tbl_busy"},  busy,       tbl[i].bsy);
         chk({tg, ".tbl_len"},   length,     tbl[i].len);
         chk({tg, ".tbl_full"},  full,       0);
         chk({tg, ".tbl_match"}, match,      tbl[i].m);
         chk({tg, ".tbl_mism"},  mismatch,   tbl[i].mm);
         chk({tg, ".tbl_done"},  seq_done,   tbl[i].d);
      end

      // Wrong second entry -> FAIL, append ignored there, replay from FAIL, clear mid-SHOW.
      cyc("fail_play", 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 2 * (3 + AUTO); i++) cyc("fail_tick", 0, 0, 0, 1, 0, 0, 0);
      cyc("fail_ok7", 0, 0, 0, 0, 1, 7, 0);
      chk("fail_ok7.match_seen", match, 1);
      cyc("fail_bad5", 0, 0, 0, 0, 1, 5, 0);
      chk("fail_bad5.mismatch_seen", mismatch, 1);
      cyc("fail_hold", 0, 0, 0, 0, 0, 0, 0);
      chk("fail_hold.busy_held", busy, 1);
      cyc("fail_app", 1, 3, 0, 0, 0, 0, 0);
      chk("fail_app.len_kept", length, 3 + AUTO);
      cyc("fail_replay", 0, 0, 1, 0, 0, 0, 0);
      chk("fail_replay.disp7", disp_digit, 7);
      cyc("clr_show", 0, 0, 0, 0, 0, 0, 1);
      chk("clr_show.disp_blank", disp_digit, 31);
      chk("clr_show.timer_off", timer_en, 0);
      chk("clr_show.len0", length, 0);

      cyc("play_empty", 0, 0, 1, 0, 0, 0, 0);
      chk("play_empty.busy0", busy, 0);

      for (int i = 0; i < 17; i++) cyc("fill", 1, $urandom_range(15), 0, 0, 0, 0, 0);
      chk("fill.len16", length, 16);
      chk("fill.full", full, 1);

      // Async reset while in the gap between digits.
      cyc("gap_play", 0, 0, 1, 0, 0, 0, 0);
      cyc("gap_tick", 0, 0, 0, 1, 0, 0, 0);
      #2;
      rst_n = 0;
      #1;
      model_reset();
      check_all("rst_gap");
      chk("rst_gap.disp_blank", disp_digit, 31);
      @(negedge clk);
      rst_n = 1;
      @(posedge clk);
      #1;

      for (int n = 0; n < 4000; n++) begin
         bit a, p, t, cv, cl;
         int rin, cd;
         cl  = ($urandom_range(199) == 0);
         a   = ($urandom_range(5) == 0);
         p   = ($urandom_range(7) == 0);
         t   = ($urandom_range(2) == 0);
         cv  = ($urandom_range(2) == 0);
         rin = $urandom_range(15);
         cd  = $urandom_range(15);
         if (in_entry() && $urandom_range(7) != 0) cd = mq[m_entered];
         if (a && mq.size() == MAXL) p = 0;
         cyc("rand", a, rin, p, t, cv, cd, cl);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_player.md
Name: seq_player

Overview:
- Sequence store and playback engine that sits between the RNG/button shaper and the 1 s timer and seven-seg display path.
- Accumulates random digits into an on-chip sequence memory and replays it one digit per timer pulse.
- Then checks player entries against the stored sequence, one digit at a time, and reports match, mismatch and completion to the game controller.

Parameters:
- MAX_LEN, 16, maximum sequence length in digits.
- DIGIT_W, 4, width of each stored digit.
- BLANK, 5'd31, display code driven when no digit is shown (the seven-seg decoder renders it blank).

Ports:
- Clk  in  1  system clock.
- Rst  in  1  asynchronous, active-low reset.
- append  in  1  one-cycle pulse; store rand_in as the next digit.
- rand_in  in  DIGIT_W  digit from the RNG.
- play  in  1  one-cycle pulse; start playback.
- tick  in  1  one-cycle pulse from the 1 s timer.
- check_valid  in  1  one-cycle pulse; the player has entered check_digit.
- check_digit  in  DIGIT_W  player switch value.
- clear  in  1  one-cycle pulse; empty the sequence and abort any operation.
- timer_en  out  1  enables the 1 s timer.
- disp_digit  out  5  digit to display: zero-extended stored digit, or BLANK.
- busy  out  1  high when not in IDLE.
- full  out  1  length == MAX_LEN.
- length  out  LEN_W = $clog2(MAX_LEN+1)  number of stored digits.
- match  out  1  one-cycle pulse; a correct entry was accepted.
- mismatch  out  1  one-cycle pulse; a wrong entry was seen.
- seq_done  out  1  one-cycle pulse; the whole sequence was entered correctly.

Behaviour:
- Reset (Rst low, async):
  - length=0, state IDLE, index=0.
  - disp_digit=BLANK; timer_en, match, mismatch, seq_done, busy all 0.
  - Memory contents are don't-care.
- All outputs are registered.
- States: IDLE, SHOW, GAP, ENTRY, FAIL.
- Priority: clear > append > play > tick/check. clear from any state: length=0, index=0, go to IDLE, disp_digit=BLANK, pulse outputs 0 next cycle.
- IDLE:
  - append with !full: mem[length] <= rand_in; length+1.
  - append when full: ignored, length unchanged.
  - play with length>0: index=0, go to SHOW. play with length==0 is ignored.
  - Same-cycle append and play: append is applied and play is ignored.
  - tick and check_valid are ignored.
- SHOW:
  - disp_digit = mem[index], valid on the cycle after the play pulse (one-cycle latency). timer_en=1.
  - tick: go to GAP, disp_digit=BLANK.
- GAP:
  - timer_en=1.
  - tick with index<length-1: index+1, go to SHOW.
  - tick with index==length-1: index=0, timer_en=0, go to ENTRY.
- ENTRY:
  - disp_digit=BLANK, timer_en=0.
  - check_valid with check_digit==mem[index]: match pulse.
    - If index==length-1 (last digit): also seq_done pulse, index=0, go to IDLE.
    - Otherwise: index+1.
  - check_valid with wrong digit: mismatch pulse, go to FAIL.
- FAIL:
  - Holds (busy=1) until clear, or until play replays the sequence (go to SHOW, index=0).
  - append is ignored.
- append, play and check_valid are ignored in any state where not listed above.
- Reset mid-playback returns everything to reset values immediately.
- The index counter never wraps past length-1.

Optional Feature:
- Macro: SEQ_AUTO_APPEND_EN.
- Defined: in the same cycle as seq_done, if !full, rand_in is appended (length+1). The controller gets the next level without issuing append.
- Defined and full at seq_done: no append; seq_done still pulses.
- Undefined: seq_done does not modify memory or length.

Decomposition:
- Shared package memgame_pkg:
  - state enum (IDLE, SHOW, GAP, ENTRY, FAIL);
  - BLANK display code constant;
  - DIGIT_W default;
  - LEN_W helper function.
- One sub-module: seq_mem, a MAX_LEN x DIGIT_W register file with one write port and one async read port.
- The FSM, counters and compare logic stay in seq_player.

Test Plan:
- Reset then 3 appends (rand_in 7, 2, 9) -> length=3, full=0, busy=0, disp_digit=31.
- play, then 6 ticks -> disp sequence 7, 31, 2, 31, 9, 31; timer_en high from the cycle after play until the 6th tick; then ENTRY.
- In ENTRY, check 7, 2, 9 -> match pulses on each entry, seq_done with the third, state IDLE, length stays 3. With SEQ_AUTO_APPEND_EN and rand_in=4 -> length=4, mem[3]=4.
- In ENTRY, check 7 then 5 -> match, then mismatch; busy stays 1 (FAIL). play -> disp_digit=7 the next cycle.
- Append 17 times with MAX_LEN=16 -> length=16, full=1, 17th ignored. play with length 0 after clear -> busy stays 0.
- clear mid-SHOW and Rst low mid-GAP -> disp_digit=31, timer_en=0, length=0 on the next cycle (clear) and immediately (reset).
